// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - framed packet receiver draining a UART RX FIFO
module uart_frame_rx #(
  parameter int         MAX_LEN = 16,
  parameter logic [7:0] SOF     = 8'hA5,
  parameter int         TIMEOUT = 50000,
  parameter int         TO_W    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic [7:0] frame_len,
  output logic       frame_ok,
  output logic       err_len,
  output logic       err_chk,
  output logic       err_timeout
);

  localparam int              IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam bit              TO_EN     = (TIMEOUT != 0);

  localparam logic [2:0] S_HUNT = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_PAY  = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  logic [2:0]      r_state;
  logic [7:0]      r_len;
  logic [7:0]      r_acc;
  logic [7:0]      r_idx;
  logic [TO_W-1:0] r_to_cnt;
  logic [7:0]      r_buf [MAX_LEN];

  logic             w_collect;
  logic             w_take;
  logic             w_last_idx;
  logic             w_to_fire;
  logic             w_len_ok;
  logic [IDX_W-1:0] w_buf_idx;

  // States that are still gathering frame bytes from the FIFO (timeout applies here)
  assign w_collect  = (r_state == S_LEN) | (r_state == S_PAY) | (r_state == S_CHK);
  // The pop strobe doubles as the internal byte-accept condition; never pop in OUT
  assign w_take     = ~rx_empty & ((r_state == S_HUNT) | w_collect) & ~reset;
  assign rd_uart    = w_take;
  assign w_last_idx = (r_idx == (r_len - 8'd1));
  assign w_len_ok   = (r_data != 8'd0) & (r_data <= MAX_LEN_B);
  assign w_buf_idx  = r_idx[IDX_W-1:0];
  // An arriving byte on the expiry edge rescues the frame
  assign w_to_fire  = TO_EN & w_collect & ~w_take & (r_to_cnt == TO_LAST);

  assign m_valid = (r_state == S_OUT);
  assign m_data  = m_valid ? r_buf[w_buf_idx] : 8'h00;
  assign m_last  = m_valid & w_last_idx;

  // Inter-byte idle counter: only runs while a frame is partially collected
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (w_take || !w_collect) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Payload store; contents are only meaningful once the checksum has passed
  always_ff @(posedge clk) begin
    if (w_take && (r_state == S_PAY)) begin
      r_buf[w_buf_idx] <= r_data;
    end
  end

  // Frame FSM with registered one-cycle status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_HUNT;
      r_len       <= 8'd0;
      r_acc       <= 8'd0;
      r_idx       <= 8'd0;
      frame_len   <= 8'd0;
      frame_ok    <= 1'b0;
      err_len     <= 1'b0;
      err_chk     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      frame_ok    <= 1'b0;
      err_len     <= 1'b0;
      err_chk     <= 1'b0;
      err_timeout <= 1'b0;
      case (r_state)
        S_HUNT: begin
          if (w_take && (r_data == SOF)) begin
            r_state <= S_LEN;
          end
        end
        S_LEN: begin
          if (w_take) begin
            // A LEN equal to SOF is just a length; no resync on it
            if (w_len_ok) begin
              r_len   <= r_data;
              r_acc   <= r_data;
              r_idx   <= 8'd0;
              r_state <= S_PAY;
            end else begin
              err_len <= 1'b1;
              r_state <= S_HUNT;
            end
          end else if (w_to_fire) begin
            err_timeout <= 1'b1;
            r_state     <= S_HUNT;
          end
        end
        S_PAY: begin
          if (w_take) begin
            r_acc <= r_acc + r_data;
            r_idx <= r_idx + 8'd1;
            if (w_last_idx) begin
              r_state <= S_CHK;
            end
          end else if (w_to_fire) begin
            err_timeout <= 1'b1;
            r_state     <= S_HUNT;
          end
        end
        S_CHK: begin
          if (w_take) begin
            if (r_data == r_acc) begin
              frame_ok  <= 1'b1;
              frame_len <= r_len;
              r_idx     <= 8'd0;
              r_state   <= S_OUT;
            end else begin
              err_chk <= 1'b1;
              r_state <= S_HUNT;
            end
          end else if (w_to_fire) begin
            err_timeout <= 1'b1;
            r_state     <= S_HUNT;
          end
        end
        S_OUT: begin
          if (m_ready) begin
            if (w_last_idx) begin
              r_state <= S_HUNT;
            end else begin
              r_idx <= r_idx + 8'd1;
            end
          end
        end
        default: begin
          r_state <= S_HUNT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - directed self-checking bench for uart_frame_rx
module tb_uart_frame_rx;

  logic       clk;
  logic       reset;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic [7:0] frame_len;
  logic       frame_ok;
  logic       err_len;
  logic       err_chk;
  logic       err_timeout;

  int total;
  int bad;

  logic [7:0] mem [256];
  int wp;
  int rp;
  int pops;
  int xfers;
  int multi;
  int p0;
  int x0;
  int k;
  int cyc;
  logic [7:0] exp_d [4];

  uart_frame_rx #(
    .MAX_LEN(16),
    .SOF    (8'hA5),
    .TIMEOUT(8),
    .TO_W   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_empty   (rx_empty),
    .r_data     (r_data),
    .rd_uart    (rd_uart),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .frame_len  (frame_len),
    .frame_ok   (frame_ok),
    .err_len    (err_len),
    .err_chk    (err_chk),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: head byte is visible while non-empty, popped on rd_uart
  assign rx_empty = (rp == wp);
  assign r_data   = mem[rp[7:0]];

  always @(posedge clk) begin
    if (rd_uart) begin
      rp   <= rp + 1;
      pops <= pops + 1;
    end
    if (m_valid && m_ready) begin
      xfers <= xfers + 1;
    end
  end

  always @(negedge clk) begin
    if ($countones({frame_ok, err_len, err_chk, err_timeout}) > 1) begin
      multi <= multi + 1;
    end
  end

  task automatic push(input logic [7:0] b);
    mem[wp[7:0]] = b;
    wp = wp + 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_d(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic no_pulse(input string tag);
    chk_b({tag, "_ok"},  frame_ok,    1'b0);
    chk_b({tag, "_len"}, err_len,     1'b0);
    chk_b({tag, "_chk"}, err_chk,     1'b0);
    chk_b({tag, "_to"},  err_timeout, 1'b0);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    wp      = 0;
    reset   = 1'b1;
    m_ready = 1'b1;

    // ---- reset state, with a good frame already waiting in the FIFO
    push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h69);
    step();
    step();
    chk_b("rst_rd_uart", rd_uart, 1'b0);
    chk_b("rst_m_valid", m_valid, 1'b0);
    chk_b("rst_m_last", m_last, 1'b0);
    chk_d("rst_m_data", m_data, 8'h00);
    chk_d("rst_frame_len", frame_len, 8'h00);
    no_pulse("rst");

    // ---- good frame A5 03 11 22 33 69
    p0 = pops;
    reset = 1'b0;
    #1;
    chk_b("g_rd_uart_first", rd_uart, 1'b1);
    repeat (5) begin
      step();
      chk_b("g_collect_valid", m_valid, 1'b0);
      no_pulse("g_collect");
    end
    step();
    chk_b("g_frame_ok", frame_ok, 1'b1);
    chk_b("g_err_chk", err_chk, 1'b0);
    chk_b("g_valid0", m_valid, 1'b1);
    chk_d("g_len", frame_len, 8'h03);
    chk_d("g_d0", m_data, 8'h11);
    chk_b("g_last0", m_last, 1'b0);
    step();
    chk_b("g_ok_drop", frame_ok, 1'b0);
    chk_d("g_d1", m_data, 8'h22);
    chk_b("g_last1", m_last, 1'b0);
    step();
    chk_d("g_d2", m_data, 8'h33);
    chk_b("g_last2", m_last, 1'b1);
    step();
    chk_b("g_valid_end", m_valid, 1'b0);
    chk_d("g_len_hold", frame_len, 8'h03);
    chk_i("g_pops", pops - p0, 6);

    // ---- bad checksum, then a one-byte good frame
    push(8'hA5); push(8'h02); push(8'h10); push(8'h20); push(8'h00);
    push(8'hA5); push(8'h01); push(8'h7E); push(8'h7F);
    repeat (4) begin
      step();
      chk_b("bc_valid_pre", m_valid, 1'b0);
      no_pulse("bc_pre");
    end
    step();
    chk_b("bc_err_chk", err_chk, 1'b1);
    chk_b("bc_ok", frame_ok, 1'b0);
    chk_b("bc_valid", m_valid, 1'b0);
    repeat (3) begin
      step();
      chk_b("bc_valid_mid", m_valid, 1'b0);
      no_pulse("bc_mid");
    end
    step();
    chk_b("bc2_ok", frame_ok, 1'b1);
    chk_d("bc2_data", m_data, 8'h7E);
    chk_b("bc2_last", m_last, 1'b1);
    chk_d("bc2_len", frame_len, 8'h01);
    step();
    chk_b("bc2_valid_end", m_valid, 1'b0);

    // ---- noise and length errors
    push(8'h00); push(8'hFF); push(8'hA5); push(8'h00); push(8'hA5);
    push(8'h11); push(8'hA5); push(8'h01); push(8'h05); push(8'h06);
    repeat (3) begin
      step();
      no_pulse("ln_junk");
    end
    step();
    chk_b("ln_err_len0", err_len, 1'b1);
    step();
    no_pulse("ln_gap");
    step();
    chk_b("ln_err_len17", err_len, 1'b1);
    repeat (3) begin
      step();
      no_pulse("ln_pre");
      chk_b("ln_valid_pre", m_valid, 1'b0);
    end
    step();
    chk_b("ln_ok", frame_ok, 1'b1);
    chk_d("ln_data", m_data, 8'h05);
    chk_b("ln_last", m_last, 1'b1);
    step();
    chk_b("ln_valid_end", m_valid, 1'b0);

    // ---- timeout after A5 02 10 with the FIFO running dry
    push(8'hA5); push(8'h02); push(8'h10);
    repeat (3) step();
    for (int i = 1; i <= 7; i++) begin
      step();
      chk_b("to_quiet", err_timeout, 1'b0);
    end
    step();
    chk_b("to_fire", err_timeout, 1'b1);
    chk_b("to_fire_chk", err_chk, 1'b0);
    step();
    chk_b("to_fire_drop", err_timeout, 1'b0);

    // ---- byte arriving in idle cycle 7 keeps the frame alive
    push(8'hA5); push(8'h02); push(8'h10);
    repeat (3) step();
    repeat (6) begin
      step();
      chk_b("ka_quiet", err_timeout, 1'b0);
    end
    push(8'h20); push(8'h32);
    step();
    chk_b("ka_saved", err_timeout, 1'b0);
    step();
    chk_b("ka_ok", frame_ok, 1'b1);
    chk_b("ka_to", err_timeout, 1'b0);
    chk_d("ka_d0", m_data, 8'h10);
    step();
    chk_d("ka_d1", m_data, 8'h20);
    chk_b("ka_last", m_last, 1'b1);
    step();
    chk_b("ka_valid_end", m_valid, 1'b0);

    // ---- backpressure with a second frame queued behind
    push(8'hA5); push(8'h04); push(8'h01); push(8'h02); push(8'h03); push(8'h04); push(8'h0E);
    push(8'hA5); push(8'h01); push(8'h09); push(8'h0A);
    exp_d[0] = 8'h01; exp_d[1] = 8'h02; exp_d[2] = 8'h03; exp_d[3] = 8'h04;
    repeat (7) step();
    chk_b("bp_ok", frame_ok, 1'b1);
    p0  = pops;
    x0  = xfers;
    k   = 0;
    cyc = 0;
    while (k < 4 && cyc < 40) begin
      m_ready = (cyc % 3 == 0);
      #1;
      chk_b("bp_valid", m_valid, 1'b1);
      chk_d("bp_data", m_data, exp_d[k]);
      chk_b("bp_last", m_last, k == 3);
      chk_b("bp_no_pop", rd_uart, 1'b0);
      step();
      if (m_ready) k = k + 1;
      cyc = cyc + 1;
    end
    chk_i("bp_done", k, 4);
    chk_i("bp_xfers", xfers - x0, 4);
    chk_i("bp_pops_out", pops - p0, 0);
    m_ready = 1'b1;
    #1;
    chk_b("bp_valid_end", m_valid, 1'b0);
    chk_b("bp_next_pop", rd_uart, 1'b1);
    repeat (4) step();
    chk_b("bp2_ok", frame_ok, 1'b1);
    chk_d("bp2_data", m_data, 8'h09);
    chk_b("bp2_last", m_last, 1'b1);
    step();
    chk_b("bp2_valid_end", m_valid, 1'b0);

    // ---- reset in the middle of the payload
    push(8'hA5); push(8'h04); push(8'h01); push(8'h02);
    repeat (4) step();
    reset = 1'b1;
    #1;
    chk_b("mr_valid", m_valid, 1'b0);
    chk_b("mr_last", m_last, 1'b0);
    chk_d("mr_data", m_data, 8'h00);
    chk_d("mr_len", frame_len, 8'h00);
    chk_b("mr_rd", rd_uart, 1'b0);
    no_pulse("mr");
    step();
    reset = 1'b0;
    push(8'hA5); push(8'h02); push(8'h33); push(8'h44); push(8'h79);
    repeat (5) step();
    chk_b("mr_ok", frame_ok, 1'b1);
    chk_d("mr_len2", frame_len, 8'h02);
    chk_d("mr_d0", m_data, 8'h33);
    step();
    chk_d("mr_d1", m_data, 8'h44);
    chk_b("mr_last2", m_last, 1'b1);
    step();
    chk_b("mr_valid_end", m_valid, 1'b0);

    chk_i("pulse_exclusive", multi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Framed-packet receiver that sits directly downstream of the UART receive FIFO. It pops bytes through the FIFO's `rd_uart`/`rx_empty`/`r_data` read port and hunts for a start-of-frame byte. It then collects a length byte, a payload and a checksum byte, and releases the payload on a valid/ready byte stream only after the checksum passes. Malformed, corrupted or stalled frames are dropped and reported on one-cycle error pulses.

## Interface

- `MAX_LEN`, 16: maximum payload bytes per frame (1..255); sets internal buffer depth.
- `SOF`, 8'hA5: start-of-frame byte value.
- `TIMEOUT`, 50000: idle clock cycles tolerated between bytes inside a frame; 0 disables the timeout.
- `TO_W`, 16: timeout counter width; `TIMEOUT` < 2^`TO_W`.
- `clk`  in  1  system clock, shared with the UART.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_empty`  in  1  UART RX FIFO empty flag.
- `r_data`  in  8  UART RX FIFO head byte, valid whenever `rx_empty`=0.
- `rd_uart`  out  1  pop strobe to the RX FIFO; the byte on `r_data` is consumed in the same cycle.
- `m_data`  out  8  payload byte out.
- `m_valid`  out  1  `m_data` valid.
- `m_ready`  in  1  downstream accepts `m_data`.
- `m_last`  out  1  marks the final payload byte of a frame.
- `frame_len`  out  8  LEN of the frame being drained; held until the next frame enters OUT.
- `frame_ok`  out  1  one-cycle pulse: frame accepted.
- `err_len`  out  1  one-cycle pulse: LEN was 0 or greater than `MAX_LEN`.
- `err_chk`  out  1  one-cycle pulse: checksum mismatch.
- `err_timeout`  out  1  one-cycle pulse: inter-byte timeout.

## Operation

- Frame format: `SOF`, LEN, LEN payload bytes, CHK.
- Checksum rule: CHK = (LEN + sum of payload bytes) mod 256, using an 8-bit wrapping accumulator.
- States: HUNT, LEN, PAY, CHK, OUT.
- Byte consume condition (`take`): `rd_uart` = `take` = ~`rx_empty` & state ∈ {HUNT, LEN, PAY, CHK} & ~`reset`.
- HUNT:
  - On `take` with `r_data`==`SOF`, go to LEN.
  - Any other byte is consumed and silently dropped.
- LEN:
  - On `take` with 1 ≤ `r_data` ≤ `MAX_LEN`: store len, set acc=`r_data`, set idx=0, go to PAY.
  - Otherwise pulse `err_len` and go to HUNT. A LEN equal to `SOF` is treated as a length, not a restart.
- PAY:
  - On `take`: write buf[idx]=`r_data`, acc+=`r_data`, idx++.
  - After the byte with idx==len-1 is taken, go to CHK.
- CHK:
  - On `take` with `r_data`==acc: pulse `frame_ok`, load `frame_len`=len, set idx=0, go to OUT.
  - On `take` with any other value: pulse `err_chk` and go to HUNT; the buffer contents are discarded.
- OUT:
  - `m_valid`=1, `m_data`=buf[idx], `m_last`=(idx==len-1).
  - On `m_valid`&`m_ready`: idx++.
  - The transfer with `m_last`=1 returns the block to HUNT.
  - No bytes are popped in OUT; the next frame waits in the RX FIFO.
- Timeout:
  - Counter clears on every `take` and whenever state is HUNT or OUT.
  - Otherwise it increments each cycle.
  - On the edge where the counter == `TIMEOUT`-1 with no `take`: go to HUNT and pulse `err_timeout`.
  - `take` in that same cycle wins, and the counter clears.
- Idle state is HUNT. Reset at any point aborts the frame, empties the buffer logically and returns to HUNT.

## Timing

- Reset values: state HUNT; `rd_uart`=0 while `reset` is high; `m_valid`, `m_last`, `frame_ok`, `err_*` = 0; `m_data`=0; `frame_len`=0.
- Throughput: one byte consumed per cycle whenever the FIFO is non-empty in HUNT through CHK.
- `frame_ok`/`err_*` are registered and high exactly in the cycle after the edge that consumed the deciding byte.
- `m_valid` rises in the same cycle as `frame_ok`.
- Drain: with `m_ready` held at 1, a LEN-byte frame drains in LEN cycles.
- Back-to-back frames: the first pop of the next frame occurs in the cycle after the `m_last` transfer.
- Hold under backpressure: while `m_valid`=1 and `m_ready`=0, `m_data`/`m_last` hold stable.
- Pulse exclusivity: at most one of `frame_ok`/`err_len`/`err_chk`/`err_timeout` is high in any cycle.

## Test plan

- Good frame: A5 03 11 22 33 69 with `m_ready`=1 -> `frame_ok` pulse, `frame_len`=3, outputs 11, 22, 33 on consecutive cycles with `m_last` on 33, and `rd_uart` pulsed 6 times.
- Bad checksum: A5 02 10 20 00 -> `err_chk` one cycle after 00 is taken, `m_valid` never rises; a following A5 01 7E 7F -> output 7E with `m_last`.
- Noise and length errors: 00 FF A5 00 A5 11 A5 01 05 06 -> `err_len` twice (LEN 00 and LEN 0x11 with `MAX_LEN`=16), then one good frame outputting 05; junk bytes dropped with no pulses.
- Timeout (`TIMEOUT`=8): A5 02 10, then FIFO empty -> `err_timeout` pulse exactly 8 idle cycles after 10 is taken; a byte arriving at idle cycle 7 keeps the frame alive.
- Backpressure: good 4-byte frame with `m_ready` toggling 1,0,0,1,… -> data held stable while stalled, 4 transfers total, and `rd_uart`=0 throughout OUT even with a second frame queued in the FIFO.
- Reset mid-PAY: assert `reset` after A5 04 01 02 -> all outputs return to reset values immediately; a subsequent full good frame is accepted normally.
